// File: rtl/hack_pkg.sv
// Shared constants, instruction field positions, decoded-instruction struct
// and jump-condition helper for the Hack CPU control stage.
package hack_pkg;

    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 15;

    localparam int I_TYPE  = 15;
    localparam int A_BIT   = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JLT     = 2;
    localparam int JEQ     = 1;
    localparam int JGT     = 0;

    typedef struct packed {
        logic              is_c;
        logic              a;
        logic [5:0]        ctrl;
        logic [2:0]        dest;
        logic [2:0]        jmp;
        logic [WORD_W-1:0] imm;
    } decode_t;

    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[JLT] & ng) | (j[JEQ] & zr) | (j[JGT] & ~zr & ~ng);
    endfunction

endpackage

// File: rtl/hack_decode.sv
// Combinational Hack instruction field decoder.
module hack_decode
    import hack_pkg::*;
(
    input  logic [WORD_W-1:0] instr_i,
    output decode_t           dec_o
);

    // Split the instruction word into its fields; imm is the A-instruction load value
    always_comb begin
        dec_o.is_c = instr_i[I_TYPE];
        dec_o.a    = instr_i[A_BIT];
        dec_o.ctrl = instr_i[CTRL_HI:CTRL_LO];
        dec_o.dest = instr_i[DEST_A:DEST_M];
        dec_o.jmp  = instr_i[JLT:JGT];
        dec_o.imm  = {1'b0, instr_i[I_TYPE-1:0]};
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage with valid/ready fetch and data handshake.
// Optional end-loop halt detection is built when HACK_HALT_DETECT_EN is defined.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int PC_W  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] instr,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] in_m,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic [WIDTH-1:0] out_m,
    output logic             write_m,
    output logic [PC_W-1:0]  address_m,
    output logic [PC_W-1:0]  pc,
    output logic             commit,
    output logic             halted
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_inc_s;
    logic [PC_W-1:0]  target_s;
    decode_t          dec_s;
    logic             a_sel_s;
    logic             mem_req_s;
    logic             jump_s;
    logic             commit_s;
    logic             halted_s;

    hack_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec_s)
    );

    assign a_sel_s   = dec_s.is_c & dec_s.a;
    assign mem_req_s = dec_s.is_c & (dec_s.a | dec_s.dest[0]);
    assign jump_s    = dec_s.is_c & jump_taken(dec_s.jmp, alu_zr, alu_ng);
    assign commit_s  = instr_valid & (~mem_req_s | mem_ready) & ~halted_s;
    // Jump target and data address both come from the pre-edge A value
    assign target_s  = a_q[PC_W-1:0];
    assign pc_inc_s  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    assign alu_x     = d_q;
    assign alu_y     = a_sel_s ? in_m : a_q;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = dec_s.ctrl;
    assign out_m     = alu_out;
    assign write_m   = instr_valid & dec_s.is_c & dec_s.dest[0] & ~halted_s;
    assign address_m = a_q[PC_W-1:0];
    assign pc        = pc_q;
    assign commit    = commit_s;

    // Next-state for A, D and PC; everything holds unless the instruction retires
    always_comb begin
        a_d  = a_q;
        d_d  = d_q;
        pc_d = pc_q;
        if (commit_s) begin
            if (dec_s.is_c) begin
                if (dec_s.dest[2]) begin
                    a_d = alu_out;
                end else begin
                    a_d = a_q;
                end
                if (dec_s.dest[1]) begin
                    d_d = alu_out;
                end else begin
                    d_d = d_q;
                end
                if (jump_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_inc_s;
                end
            end else begin
                a_d  = dec_s.imm;
                pc_d = pc_inc_s;
            end
        end else begin
            a_d  = a_q;
            d_d  = d_q;
            pc_d = pc_q;
        end
    end

    // Architectural register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= {WIDTH{1'b0}};
            d_q  <= {WIDTH{1'b0}};
            pc_q <= {PC_W{1'b0}};
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

`ifdef HACK_HALT_DETECT_EN
    logic            halted_q, halted_d;
    logic            prev_a_q, prev_a_d;
    logic [PC_W-1:0] prev_pc_q, prev_pc_d;
    logic            halt_set_s;

    // A taken jump to itself, or back to the "@N" that immediately preceded it, never exits
    assign halt_set_s = commit_s & jump_s &
                        ((target_s == pc_q) | (prev_a_q & (target_s == prev_pc_q)));

    // Track the last retired instruction and latch the sticky halt flag
    always_comb begin
        halted_d  = halted_q;
        prev_a_d  = prev_a_q;
        prev_pc_d = prev_pc_q;
        if (commit_s) begin
            prev_a_d  = ~dec_s.is_c;
            prev_pc_d = pc_q;
            halted_d  = halted_q | halt_set_s;
        end else begin
            halted_d  = halted_q;
        end
    end

    // Halt detection state; only rst_n leaves the halted state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q  <= 1'b0;
            prev_a_q  <= 1'b0;
            prev_pc_q <= {PC_W{1'b0}};
        end else begin
            halted_q  <= halted_d;
            prev_a_q  <= prev_a_d;
            prev_pc_q <= prev_pc_d;
        end
    end

    assign halted_s = halted_q;
`else
    assign halted_s = 1'b0;
`endif

    assign halted = halted_s;

endmodule
